// File: rtl/contour_vertex_extract_if.sv
// contour_vertex_extract_if: vertex stream from the contour vertex extractor.
// master drives valid/x/y, slave drives ready.
interface contour_vertex_extract_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           vertex_valid;
  logic           vertex_ready;
  logic [X_W-1:0] vertex_x;
  logic [Y_W-1:0] vertex_y;

  modport master (
    output vertex_valid,
    output vertex_x,
    output vertex_y,
    input  vertex_ready
  );

  modport slave (
    input  vertex_valid,
    input  vertex_x,
    input  vertex_y,
    output vertex_ready
  );
endinterface

// File: rtl/contour_vertex_extract.sv
// contour_vertex_extract: reduces a traced contour point list to polygon vertices.
// Define CONTOUR_BBOX_EN to add bounding-box outputs.
module contour_vertex_extract #(
  parameter int ADDR_W  = 14,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int MIN_RUN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    num_points,
  output logic [ADDR_W-1:0]    edge_addr,
  output logic                 edge_en,
  input  logic [X_W+Y_W-1:0]   edge_data,
  contour_vertex_extract_if.master vtx,
  output logic [ADDR_W-1:0]    vertex_count,
  output logic                 busy,
  output logic                 done,
  output logic                 gap_err
`ifdef CONTOUR_BBOX_EN
  ,
  output logic [X_W-1:0]       bbox_xmin,
  output logic [X_W-1:0]       bbox_xmax,
  output logic [Y_W-1:0]       bbox_ymin,
  output logic [Y_W-1:0]       bbox_ymax
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_CLASSIFY,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic signed [X_W:0] XONE = 1;
  localparam logic signed [Y_W:0] YONE = 1;
  localparam logic [3:0] RUN_MIN = 4'(MIN_RUN);

  state_t state, state_n;

  logic [ADDR_W-1:0] idx, idx_inc, npts;
  logic [X_W-1:0]    cur_x, prev_x, vx;
  logic [Y_W-1:0]    cur_y, prev_y, vy;
  logic [2:0]        dir, dir_new;
  logic [3:0]        run;

  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic dx_n, dx_z, dx_p, dy_n, dy_z, dy_p;
  logic first, last, dup, gap, same, turn, emit;

  assign idx_inc = idx + 1'b1;
  assign last    = (idx_inc == npts);
  assign first   = (idx == '0);

  assign dx = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x});
  assign dy = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y});

  assign dx_n = dx < 0;
  assign dx_p = dx > 0;
  assign dx_z = !dx_n && !dx_p;
  assign dy_n = dy < 0;
  assign dy_p = dy > 0;
  assign dy_z = !dy_n && !dy_p;

  always_comb begin
    dir_new = 3'd0;
    unique case (1'b1)
      dy_n && dx_z: dir_new = 3'd0;
      dy_n && dx_p: dir_new = 3'd1;
      dy_z && dx_p: dir_new = 3'd2;
      dy_p && dx_p: dir_new = 3'd3;
      dy_p && dx_z: dir_new = 3'd4;
      dy_p && dx_n: dir_new = 3'd5;
      dy_z && dx_n: dir_new = 3'd6;
      dy_n && dx_n: dir_new = 3'd7;
      default:      dir_new = 3'd0;
    endcase
  end

  // run == 0 after point 0 or a gap, so any step then starts a fresh run
  assign dup  = !first && dx_z && dy_z;
  assign gap  = !first && (dx > XONE || dx < -XONE ||
                           dy > YONE || dy < -YONE);
  assign same = (dir_new == dir);
  assign turn = !first && !dup && !gap && !same && (run >= RUN_MIN);
  assign emit = first || gap || turn;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = (num_points == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: state_n = S_CLASSIFY;
      S_CLASSIFY:
        if (emit)      state_n = S_EMIT;
        else if (last) state_n = S_DONE;
        else           state_n = S_FETCH;
      S_EMIT:
        if (vtx.vertex_ready) state_n = last ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      npts         <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      prev_x       <= '0;
      prev_y       <= '0;
      dir          <= '0;
      run          <= '0;
      vx           <= '0;
      vy           <= '0;
      vertex_count <= '0;
      gap_err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (start) begin
            idx          <= '0;
            npts         <= num_points;
            vertex_count <= '0;
            gap_err      <= 1'b0;
            dir          <= '0;
            run          <= '0;
          end
        S_LATCH: begin
          cur_x <= edge_data[X_W+Y_W-1:Y_W];
          cur_y <= edge_data[Y_W-1:0];
        end
        S_CLASSIFY: begin
          if (!dup) begin
            prev_x <= cur_x;
            prev_y <= cur_y;
          end
          if (first || gap) begin
            run <= '0;
            vx  <= cur_x;
            vy  <= cur_y;
          end else if (!dup && same) begin
            run <= (run == 4'd15) ? run : run + 4'd1;
          end else if (!dup) begin
            dir <= dir_new;
            run <= 4'd1;
            if (turn) begin
              vx <= prev_x;
              vy <= prev_y;
            end
          end
          if (gap) gap_err <= 1'b1;
          if (!emit && !last) idx <= idx_inc;
        end
        S_EMIT:
          if (vtx.vertex_ready) begin
            vertex_count <= vertex_count + 1'b1;
            if (!last) idx <= idx_inc;
          end
        default: ;
      endcase
    end
  end

`ifdef CONTOUR_BBOX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else if (state == S_CLASSIFY && first) begin
      bbox_xmin <= cur_x;
      bbox_xmax <= cur_x;
      bbox_ymin <= cur_y;
      bbox_ymax <= cur_y;
    end else if (state == S_CLASSIFY && !dup) begin
      if (cur_x < bbox_xmin) bbox_xmin <= cur_x;
      if (cur_x > bbox_xmax) bbox_xmax <= cur_x;
      if (cur_y < bbox_ymin) bbox_ymin <= cur_y;
      if (cur_y > bbox_ymax) bbox_ymax <= cur_y;
    end
  end
`endif

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign edge_en   = (state == S_FETCH);
  assign edge_addr = edge_en ? idx : '0;

  assign vtx.vertex_valid = (state == S_EMIT);
  assign vtx.vertex_x     = vx;
  assign vtx.vertex_y     = vy;

endmodule
